// File: rtl/rib_pkg.sv
// ---------------------------------------------------------------------------
// rib_pkg
// Shared definitions for the RIB two-master / four-slave interconnect:
//   - slave index constants (ROM, RAM, timer, UART)
//   - position of the slave decode field inside the address
//   - bus-ownership state encoding
// Build option: RIB_TMO_EN (consumed by rib_arbiter, not by this package).
// ---------------------------------------------------------------------------
package rib_pkg;

  // Slave indices; also the bit position in the one-hot s_req vector.
  localparam int RIB_ROM     = 0;
  localparam int RIB_RAM     = 1;
  localparam int RIB_TIMER   = 2;
  localparam int RIB_UART    = 3;
  localparam int RIB_NUM_SLV = 4;

  // Slave decode field addr[31:28].
  localparam int RIB_SLV_MSB = 31;
  localparam int RIB_SLV_LSB = 28;
  localparam int RIB_SLV_W   = RIB_SLV_MSB - RIB_SLV_LSB + 1;

  // Bus ownership. S_M1 (core) is the park state entered on reset.
  typedef enum logic {
    S_M1 = 1'b0,
    S_M0 = 1'b1
  } rib_state_e;

endpackage : rib_pkg

// File: rtl/rib_decode.sv
// ---------------------------------------------------------------------------
// rib_decode
// Combinational slave decoder. Turns the slave field of the granted address
// into a one-hot slave request, or flags a miss when the field names no slave.
// Nothing is asserted unless req is high.
//
// Ports:
//   req        in  1            granted master is requesting this cycle
//   slv_field  in  RIB_SLV_W    addr[31:28] of the granted master
//   sel        out RIB_NUM_SLV  one-hot slave request (0 rom .. 3 uart)
//   miss       out 1            req high but field outside 0..3
// ---------------------------------------------------------------------------
module rib_decode
  import rib_pkg::*;
(
  input  logic                   req,
  input  logic [RIB_SLV_W-1:0]   slv_field,
  output logic [RIB_NUM_SLV-1:0] sel,
  output logic                   miss
);

  always_comb begin
    // NOTE: every output gets a default before the case so that no path
    // leaves it unassigned; a missing default here would infer a latch.
    sel  = '0;
    miss = 1'b0;
    if (req) begin
      case (slv_field)
        RIB_SLV_W'(RIB_ROM):   sel[RIB_ROM]   = 1'b1;
        RIB_SLV_W'(RIB_RAM):   sel[RIB_RAM]   = 1'b1;
        RIB_SLV_W'(RIB_TIMER): sel[RIB_TIMER] = 1'b1;
        RIB_SLV_W'(RIB_UART):  sel[RIB_UART]  = 1'b1;
        default:               miss           = 1'b1;
      endcase
    end
  end

endmodule : rib_decode

// File: rtl/rib_arbiter.sv
// ---------------------------------------------------------------------------
// rib_arbiter
// Two-master, four-slave RIB interconnect placed between the core data port
// and ROM/RAM/timer/UART. m0 (debug/download) has priority over m1 (core),
// which owns the bus by default. One idle "switch" cycle is inserted when m0
// takes the bus and one idle "release" cycle when it gives it back. The core
// is stalled through hold_flag while it is not granted.
//
// Build option:
//   RIB_TMO_EN  when defined, m0 may own the bus for at most TMO_CYC
//               consecutive cycles; the core then gets exactly one slot
//               (hold_flag low, core served) before m0 resumes.
//               When undefined, m0 may hold the bus indefinitely.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   m0_req/we/addr/wdata/sel  debug master request path
//   m0_rdata                  debug read data (0 unless m0 is served)
//   m1_req/we/addr/wdata/sel  core request path (rib_ram_*)
//   m1_rdata                  core read data (0 unless m1 is served)
//   s_addr/s_wdata/s_sel      shared slave bus, driven by the owning master
//   s_we                      write enable, 0 whenever s_req is 0
//   s_req                     one-hot slave request: 0 rom 1 ram 2 timer 3 uart
//   s0_rdata..s3_rdata        slave read data
//   hold_flag                 stall to the core (rib_hold_flag)
//   dec_err                   one-cycle pulse the cycle after a decode miss
// ---------------------------------------------------------------------------
module rib_arbiter
  import rib_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int SEL_W   = 4,
  parameter int TMO_CYC = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  // debug master
  input  logic                   m0_req,
  input  logic                   m0_we,
  input  logic [ADDR_W-1:0]      m0_addr,
  input  logic [DATA_W-1:0]      m0_wdata,
  input  logic [SEL_W-1:0]       m0_sel,
  output logic [DATA_W-1:0]      m0_rdata,
  // core data port
  input  logic                   m1_req,
  input  logic                   m1_we,
  input  logic [ADDR_W-1:0]      m1_addr,
  input  logic [DATA_W-1:0]      m1_wdata,
  input  logic [SEL_W-1:0]       m1_sel,
  output logic [DATA_W-1:0]      m1_rdata,
  // shared slave bus
  output logic [ADDR_W-1:0]      s_addr,
  output logic [DATA_W-1:0]      s_wdata,
  output logic [SEL_W-1:0]       s_sel,
  output logic                   s_we,
  output logic [RIB_NUM_SLV-1:0] s_req,
  input  logic [DATA_W-1:0]      s0_rdata,
  input  logic [DATA_W-1:0]      s1_rdata,
  input  logic [DATA_W-1:0]      s2_rdata,
  input  logic [DATA_W-1:0]      s3_rdata,
  // status
  output logic                   hold_flag,
  output logic                   dec_err
);

  rib_state_e             state;
  rib_state_e             state_nxt;
  logic                   core_slot;   // forced one-cycle core slot (timeout)
  logic                   path_m0;     // m0 drives the shared bus signals
  logic                   grant_m0;    // m0 is served this cycle
  logic                   grant_m1;    // m1 is served this cycle
  logic                   path_req;    // granted master is requesting
  logic [RIB_NUM_SLV-1:0] dec_sel;
  logic                   dec_miss;
  logic [DATA_W-1:0]      slv_rdata;

`ifdef RIB_TMO_EN
  localparam int                CNT_W    = $clog2(TMO_CYC + 1);
  // The slot is forced at the end of the TMO_CYC-th owned cycle.
  localparam logic [CNT_W-1:0]  TMO_LAST = CNT_W'(TMO_CYC - 1);

  logic [CNT_W-1:0] tmo_cnt;
  logic [CNT_W-1:0] tmo_cnt_nxt;
  logic             core_slot_nxt;
`else
  logic unused_tmo;
  assign unused_tmo = ^TMO_CYC;
  assign core_slot  = 1'b0;
`endif

  // -------------------------------------------------------------------------
  // State register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process evaluation order.
    if (rst) begin
      state <= S_M1;
    end else begin
      state <= state_nxt;
    end
  end

`ifdef RIB_TMO_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      tmo_cnt   <= '0;
      core_slot <= 1'b0;
    end else begin
      tmo_cnt   <= tmo_cnt_nxt;
      core_slot <= core_slot_nxt;
    end
  end
`endif

  // -------------------------------------------------------------------------
  // Next-state logic. Ownership follows m0_req with one cycle of delay; the
  // optional timeout breaks a long m0 tenure with a single core slot.
  // -------------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
`ifdef RIB_TMO_EN
    tmo_cnt_nxt   = '0;
    core_slot_nxt = 1'b0;
`endif
    unique case (state)
      S_M1: begin
        if (m0_req) state_nxt = S_M0;
      end
      S_M0: begin
        if (!m0_req) begin
          state_nxt = S_M1;
`ifdef RIB_TMO_EN
        end else if (tmo_cnt == TMO_LAST) begin
          state_nxt     = S_M1;
          core_slot_nxt = 1'b1;
        end else begin
          tmo_cnt_nxt = tmo_cnt + 1'b1;
`endif
        end
      end
      default: state_nxt = S_M1;
    endcase
  end

  // -------------------------------------------------------------------------
  // Grant. In S_M1 a rising m0_req quiesces the bus (switch cycle) unless
  // this is a forced core slot; in S_M0 a falling m0_req gives an idle
  // release cycle. Nobody is served while reset is asserted.
  // -------------------------------------------------------------------------
  always_comb begin
    grant_m0 = 1'b0;
    grant_m1 = 1'b0;
    if (!rst) begin
      if (state == S_M0) begin
        grant_m0 = m0_req;
      end else begin
        grant_m1 = !m0_req || core_slot;
      end
    end
  end

  assign path_m0  = (state == S_M0);
  assign path_req = (grant_m0 & m0_req) | (grant_m1 & m1_req);

  // Shared bus signals follow the owner even in idle cycles; s_req and s_we
  // are what qualify an access.
  assign s_addr  = path_m0 ? m0_addr  : m1_addr;
  assign s_wdata = path_m0 ? m0_wdata : m1_wdata;
  assign s_sel   = path_m0 ? m0_sel   : m1_sel;

  rib_decode u_decode (
    .req       (path_req),
    .slv_field (s_addr[RIB_SLV_MSB:RIB_SLV_LSB]),
    .sel       (dec_sel),
    .miss      (dec_miss)
  );

  assign s_req = dec_sel;
  assign s_we  = (path_m0 ? m0_we : m1_we) & (|dec_sel);

  // -------------------------------------------------------------------------
  // Read data: AND-OR mux on the one-hot select; a miss or idle cycle
  // returns zero. Only the served master sees it.
  // -------------------------------------------------------------------------
  assign slv_rdata = ({DATA_W{dec_sel[RIB_ROM]}}   & s0_rdata)
                   | ({DATA_W{dec_sel[RIB_RAM]}}   & s1_rdata)
                   | ({DATA_W{dec_sel[RIB_TIMER]}} & s2_rdata)
                   | ({DATA_W{dec_sel[RIB_UART]}}  & s3_rdata);

  assign m0_rdata = grant_m0 ? slv_rdata : '0;
  assign m1_rdata = grant_m1 ? slv_rdata : '0;

  // Core stalls from the first m0 request until the cycle after it drops,
  // except during a forced core slot.
  assign hold_flag = !core_slot && (m0_req || path_m0);

  // -------------------------------------------------------------------------
  // Decode-miss pulse, one cycle after the missing access.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      dec_err <= 1'b0;
    end else begin
      dec_err <= dec_miss;
    end
  end

endmodule : rib_arbiter

// File: doc/rib_arbiter.md
Name: rib_arbiter

Overview:
- Two-master, four-slave interconnect that sits directly downstream of the core's data-bus port (rib_ram_*) and upstream of ROM/RAM/timer/UART.
- It arbitrates between the debug/download master (m0, high priority) and the core data port (m1, parked default).
- It decodes addr[31:28] to one slave and muxes read data back to the winner.
- It generates the rib_hold_flag that stalls the core while it is not granted.

Parameters:
- ADDR_W, 32, address width (MemAddrBus).
- DATA_W, 32, data width (MemBus).
- SEL_W, 4, byte-select width (MenSelBus).
- TMO_CYC, 16, max consecutive m0-granted cycles before a forced core slot (timeout feature only).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- m0_req  in  1  debug master request
- m0_we  in  1  debug write enable
- m0_addr  in  ADDR_W  debug address
- m0_wdata  in  DATA_W  debug write data
- m0_sel  in  SEL_W  debug byte select
- m0_rdata  out  DATA_W  debug read data
- m1_req  in  1  core request (rib_ram_req)
- m1_we  in  1  core write enable (rib_ram_we)
- m1_addr  in  ADDR_W  core address (rib_ram_wraddr)
- m1_wdata  in  DATA_W  core write data (rib_ram_wdata)
- m1_sel  in  SEL_W  core byte select (ram_sel)
- m1_rdata  out  DATA_W  core read data (rib_ram_rdata)
- s_addr  out  ADDR_W  shared slave address
- s_wdata  out  DATA_W  shared slave write data
- s_sel  out  SEL_W  shared byte select
- s_we  out  1  write enable, forced 0 when no s_req bit is set
- s_req  out  4  one-hot slave request: 0 rom, 1 ram, 2 timer, 3 uart
- s0_rdata..s3_rdata  in  DATA_W  slave read data
- hold_flag  out  1  stall to core (rib_hold_flag)
- dec_err  out  1  one-cycle pulse: decode miss

Behaviour:
- Reset is synchronous and active-high on rst; a single clock, clk.
- Reset values: state=S_M1, counter=0, dec_err=0. All other outputs are combinational from state.
- States:
  - S_M1: core owns the bus (park/default).
  - S_M0: debug owns the bus.
- Transitions:
  - S_M1 -> S_M0 when m0_req=1, on the next edge.
  - S_M0 -> S_M1 when m0_req=0, on the next edge.
  - Otherwise the state holds.
- Switch cycle: in S_M1 with m0_req=1, the bus is quiesced. s_req=0, s_we=0, and neither master is served.
- Release cycle: in S_M0 with m0_req=0, s_req=0.
- hold_flag = m0_req | (state==S_M0). The core therefore stalls from the first cycle m0 requests until the cycle after m0 drops.
- Granted-path routing:
  - The granted master's addr/wdata/sel/we drive s_* combinationally.
  - s_req = onehot(addr[31:28]) when the granted master's req=1 and addr[31:28] is 0..3; otherwise 0.
- Read data:
  - The granted master's rdata is the decoded slave's rdata, same cycle.
  - Non-granted master rdata = 0. Decode miss returns 0.
- Decode miss: granted req=1 with addr[31:28]>3 gives s_req=0, s_we=0, and dec_err=1 on the next cycle, for one cycle only.
- Reset mid-transfer: the state returns to S_M1 and dec_err clears. No slave access is issued in the reset cycle (s_req=0 while rst=1).
- Simultaneous m0_req and m1_req: m0 always wins. m1 is held with no side effects.

Optional Feature:
- Macro RIB_TMO_EN.
- When defined:
  - A counter of width clog2(TMO_CYC+1) increments each S_M0 cycle and clears in S_M1.
  - When the counter reaches TMO_CYC with m0_req still high, the state is forced to S_M1 for exactly one cycle. In that cycle hold_flag=0 and the core is served.
  - The state then returns to S_M0 and the counter restarts at 0.
- When undefined: no counter is built, and m0 may hold the bus indefinitely.

Decomposition:
- defines.v gains:
  - RIB slave index constants (RibRom=0, RibRam=1, RibTimer=2, RibUart=3)
  - the slave decode field RibSlvBits 31:28
  - state encodings S_M1/S_M0
- Width macros reuse MemAddrBus, MemBus and MenSelBus.
- One sub-module, rib_decode: combinational addr -> one-hot s_req plus miss flag, instantiated once on the granted address.

Test Plan:
- Core-only traffic:
  - m1 write, addr 0x1000_0010, wdata 0xDEADBEEF, sel 4'hF gives s_req=4'b0010, s_we=1, hold_flag=0 in the same cycle.
  - m1 read, s1_rdata=0x1234 gives m1_rdata=0x1234.
- Preemption:
  - m0_req rises at cycle 5 while m1 is writing. At cycle 5: hold_flag=1, s_req=0, s_we=0.
  - Cycle 6: m0 is granted.
  - m0_req falls at cycle 9 gives hold_flag=1 at cycle 9 and 0 at cycle 10.
- Decode miss: m1_req with addr 0x5000_0000 gives s_req=0, m1_rdata=0, and dec_err=1 only in the following cycle.
- Reset mid-grant: assert rst during S_M0 gives S_M1 next edge, hold_flag=m0_req, dec_err=0.
- RIB_TMO_EN with TMO_CYC=4: m0_req held for 20 cycles gives hold_flag=0 for exactly one cycle after every 4 m0-granted cycles.
- Without RIB_TMO_EN, the same stimulus gives hold_flag=1 continuously.
